// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for mem_port_arbiter: FSM state encoding, default widths,
// one-hot helper.
package arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, ACK} arb_state_t;

  localparam int ARB_ADDR_W  = 15;
  localparam int ARB_DATA_W  = 32;
  localparam int ARB_MAX_REQ = 32;

  function automatic logic [ARB_MAX_REQ-1:0] onehot_idx(input int unsigned idx);
    return {{(ARB_MAX_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational winner select: round-robin from ptr, or lowest index wins when
// ARB_FIXED_PRIO_EN is defined (ptr then unused).
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);
  logic [IDX_W-1:0] cand;

`ifdef ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      cand = IDX_W'(k);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end
`else
  // Walk downward so the candidate closest to ptr is written last and wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one read-only memory port among NUM_REQ four-phase req/ack requesters.
// ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
import arb_pkg::*;

module mem_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int DATA_W  = ARB_DATA_W,
  parameter int MEM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      mem_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_rdata
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  arb_state_t       state, state_d;
  logic [IDX_W-1:0] own, ptr, win, next_ptr;
  logic             win_vld, own_req, lat_done;
  logic [CNT_W-1:0] cnt;
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_addr
    assign addr_arr[i] = addr[i*ADDR_W +: ADDR_W];
  end

  assign own_req  = req[own];
  assign lat_done = (cnt == '0);
  assign next_ptr = (own == IDX_W'(NUM_REQ-1)) ? '0 : own + IDX_W'(1);

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (win),
    .valid (win_vld)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (win_vld)  state_d = ISSUE;
      ISSUE:                   state_d = WAIT_DATA;
      WAIT_DATA: if (lat_done) state_d = ACK;
      ACK:       if (!own_req) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

`ifdef ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                        ptr <= '0;
    else if (state == ACK && !own_req) ptr <= next_ptr;
  end
`endif

  // Outputs are all registered; addr is sampled only on the arbitration edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      own      <= '0;
      cnt      <= '0;
      ack      <= '0;
      rdata    <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
    end else begin
      busy   <= (state_d != IDLE);
      mem_en <= (state == IDLE) && win_vld;
      case (state)
        IDLE: if (win_vld) begin
          own      <= win;
          grant    <= NUM_REQ'(onehot_idx(32'(win)));
          mem_addr <= addr_arr[win];
        end
        ISSUE: cnt <= CNT_W'(MEM_LAT - 1);
        WAIT_DATA: begin
          if (lat_done) begin
            rdata <= mem_rdata;
            ack   <= grant;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ACK: if (!own_req) begin
          ack   <= '0;
          grant <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
module tb_mem_port_arbiter;
  localparam int NR = 3, AW = 15, DW = 32;

  logic clk = 1'b0, rst_b = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0] req, ack, grant, req2, ack2, grant2;
  logic [NR*AW-1:0] addr, addr2;
  logic [DW-1:0] rdata, mem_rdata, rdata2;
  logic [DW-1:0] mem_rdata2 = '0;
  logic busy, mem_en, busy2, mem_en2;
  logic [AW-1:0] mem_addr, mem_addr2;
  int cyc = 0;
  int vec = 0, errs = 0;

  mem_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut (
    .clk(clk), .rst_b(rst_b), .req(req), .addr(addr), .ack(ack), .rdata(rdata),
    .grant(grant), .busy(busy), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata));

  mem_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_b(rst_b), .req(req2), .addr(addr2), .ack(ack2), .rdata(rdata2),
    .grant(grant2), .busy(busy2), .mem_en(mem_en2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2));

  // Latency-1 memory returns C0DE0000^addr only in the cycle after mem_en, junk otherwise.
  always @(posedge clk) mem_rdata <= mem_en ? (32'hC0DE0000 ^ 32'(mem_addr)) : 32'hBAD0BAD0;
  // Latency-3 port sees a per-cycle stamp so capture timing is exact.
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    mem_rdata2 <= 32'h50000000 + 32'(cyc + 1);
  end

  function automatic int oh2i(input logic [NR-1:0] g);
    case (g)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vec++; if ({ack, grant, busy, mem_en} !== '0) begin errs++; $display("FAIL reset_ctl: got %b want 0", {ack, grant, busy, mem_en}); end
    vec++; if (rdata !== '0 || mem_addr !== '0) begin errs++; $display("FAIL reset_data: got %h/%h want 0/0", rdata, mem_addr); end
    vec++; if ({ack2, grant2, busy2, mem_en2, rdata2, mem_addr2} !== '0) begin errs++; $display("FAIL reset_lat3: outputs not zero"); end
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rr();
    int got[6], exp[6];
    int n = 0;
`ifdef ARB_FIXED_PRIO_EN
    exp = '{0, 0, 0, 0, 0, 0};
`else
    exp = '{0, 1, 2, 0, 1, 2};
`endif
    req = 3'b111;
    for (int t = 0; t < 80 && n < 6; t++) begin
      @(negedge clk);
      if (mem_en) begin got[n] = oh2i(grant); n++; end
      for (int i = 0; i < NR; i++) req[i] = ~ack[i];
    end
    req = '0;
    vec++; if (n !== 6) begin errs++; $display("FAIL rr_count: got %0d grants want 6", n); end
    for (int k = 0; k < n; k++) begin
      vec++; if (got[k] !== exp[k]) begin errs++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, got[k], exp[k]); end
    end
    repeat (8) @(negedge clk);
    vec++; if (busy !== 1'b0 || grant !== '0) begin errs++; $display("FAIL rr_idle: busy %b grant %b want 0/000", busy, grant); end
  endtask

  task automatic test_single();
    addr[1*AW +: AW] = 15'h0123;
    req = 3'b010;
    @(negedge clk);
    vec++; if (mem_en !== 1'b1 || mem_addr !== 15'h0123) begin errs++; $display("FAIL single_issue: mem_en %b addr %h want 1/0123", mem_en, mem_addr); end
    vec++; if (grant !== 3'b010 || busy !== 1'b1) begin errs++; $display("FAIL single_grant: grant %b busy %b want 010/1", grant, busy); end
    @(negedge clk);
    vec++; if (ack !== '0 || mem_en !== 1'b0) begin errs++; $display("FAIL single_wait: ack %b mem_en %b want 000/0", ack, mem_en); end
    @(negedge clk);
    vec++; if (ack !== 3'b010) begin errs++; $display("FAIL single_ack: got %b want 010", ack); end
    vec++; if (rdata !== 32'hC0DE0123) begin errs++; $display("FAIL single_rdata: got %h want c0de0123", rdata); end
    req = '0;
    @(negedge clk);
    vec++; if (ack !== '0 || grant !== '0 || busy !== 1'b0) begin errs++; $display("FAIL single_release: ack %b grant %b busy %b want 0", ack, grant, busy); end
    vec++; if (rdata !== 32'hC0DE0123) begin errs++; $display("FAIL single_rdata_hold: got %h want c0de0123", rdata); end
  endtask

  task automatic test_addr_stab();
    addr[0 +: AW] = 15'h0ABC;
    req = 3'b001;
    @(negedge clk);
    addr[0 +: AW] = 15'h7FFF;
    @(negedge clk);
    vec++; if (mem_addr !== 15'h0ABC) begin errs++; $display("FAIL stab_addr: got %h want 0abc", mem_addr); end
    @(negedge clk);
    vec++; if (ack !== 3'b001 || rdata !== 32'hC0DE0ABC) begin errs++; $display("FAIL stab_data: ack %b rdata %h want 001/c0de0abc", ack, rdata); end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_early_drop();
    int n_en = 0, n_ack = 0;
    addr[2*AW +: AW] = 15'h0042;
    req = 3'b100;
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      if (t == 1) req = '0;
      if (mem_en) n_en++;
      if (ack[2]) begin
        n_ack++;
        vec++; if (rdata !== 32'hC0DE0042) begin errs++; $display("FAIL early_rdata: got %h want c0de0042", rdata); end
      end
    end
    vec++; if (n_en !== 1) begin errs++; $display("FAIL early_mem_en: got %0d strobes want 1", n_en); end
    vec++; if (n_ack !== 1) begin errs++; $display("FAIL early_ack: got %0d ack cycles want 1", n_ack); end
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL early_idle: busy %b want 0", busy); end
  endtask

  task automatic test_latency();
    int k_en = -1, k_ack = -1, n_en = 0, c_en = 0;
    logic [DW-1:0] d_ack = '0;
    addr2[1*AW +: AW] = 15'h0055;
    req2 = 3'b010;
    for (int k = 1; k <= 12 && k_ack < 0; k++) begin
      @(negedge clk);
      if (mem_en2) begin n_en++; k_en = k; c_en = cyc; end
      if (ack2[1]) begin k_ack = k; d_ack = rdata2; end
    end
    vec++; if (k_en !== 1 || n_en !== 1) begin errs++; $display("FAIL lat3_issue: mem_en at %0d x%0d want 1 x1", k_en, n_en); end
    vec++; if (mem_addr2 !== 15'h0055) begin errs++; $display("FAIL lat3_addr: got %h want 0055", mem_addr2); end
    vec++; if (k_ack !== 5) begin errs++; $display("FAIL lat3_ack: got cycle %0d want 5", k_ack); end
    vec++; if (d_ack !== 32'h50000000 + 32'(c_en + 3)) begin errs++; $display("FAIL lat3_rdata: got %h want %h", d_ack, 32'h50000000 + 32'(c_en + 3)); end
    req2 = '0;
    @(negedge clk);
    vec++; if (ack2 !== '0 || busy2 !== 1'b0) begin errs++; $display("FAIL lat3_release: ack %b busy %b want 000/0", ack2, busy2); end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    addr[1*AW +: AW] = 15'h0011;
    addr[0 +: AW]    = 15'h0100;
    req = 3'b010;
    while (ack[1] !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    vec++; if (ack[1] !== 1'b1) begin errs++; $display("FAIL mid_pre: ack[1] %b within 20 cycles want 1", ack[1]); end
    req = '0;
    @(negedge clk);
    req = 3'b010;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    vec++; if ({ack, grant, busy, mem_en} !== '0) begin errs++; $display("FAIL mid_ctl: got %b want 0", {ack, grant, busy, mem_en}); end
    vec++; if (rdata !== '0 || mem_addr !== '0) begin errs++; $display("FAIL mid_data: got %h/%h want 0/0", rdata, mem_addr); end
    req = 3'b011;
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    vec++; if (mem_en !== 1'b1 || grant !== 3'b001) begin errs++; $display("FAIL mid_regrant: mem_en %b grant %b want 1/001", mem_en, grant); end
    repeat (2) @(negedge clk);
    vec++; if (ack !== 3'b001 || rdata !== 32'hC0DE0100) begin errs++; $display("FAIL mid_serve: ack %b rdata %h want 001/c0de0100", ack, rdata); end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    req = '0; addr = '0; req2 = '0; addr2 = '0;
    test_reset();
    test_rr();
    test_single();
    test_addr_stab();
    test_early_drop();
    test_latency();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
